wr_full_unit: RTL and testbench

WR_FULL_UNIT -- requirements
Module: wr_full_unit

---
 rtl/wr_full_unit.sv | 89 ++++++++
 tb/tb_wr_full_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/wr_full_unit.sv
// Write-side full/almost-full logic for a dual-clock stack: synchronizes the Gray read
// counter, computes occupancy against the post-write counter and registers the flags.
module wr_full_unit #(
   parameter int stk_ptr_width = 3,
   parameter int af_level      = 2
) (
   input  logic                     clk_write,
   input  logic                     rst_n,
   input  logic [stk_ptr_width:0]   wr_cntr,
   input  logic                     write_req,
   input  logic [stk_ptr_width:0]   rd_gray_async,
   output logic                     write_to_stk,
   output logic [stk_ptr_width:0]   wr_gray,
   output logic                     full,
   output logic                     almost_full,
   output logic [stk_ptr_width:0]   free_cnt,
   output logic                     wr_overflow
);

   localparam int              W        = stk_ptr_width + 1;
   localparam logic [W-1:0]    DEPTH    = W'(2 ** stk_ptr_width);
   localparam logic            AF_RESET = ((2 ** stk_ptr_width) <= af_level);

   function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
      logic [W-1:0] b;
      b[W-1] = g[W-1];
      for (int i = W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [W-1:0] rd_sync1_q, rd_sync1_d;
   logic [W-1:0] rd_sync2_q, rd_sync2_d;
   logic [W-1:0] wr_gray_q, wr_gray_d;
   logic [W-1:0] free_cnt_q, free_cnt_d;
   logic         full_q, full_d;
   logic         almost_full_q, almost_full_d;
   logic         wr_overflow_q, wr_overflow_d;

   logic [W-1:0] wr_cntr_next;
   logic [W-1:0] rd_bin;
   logic [W-1:0] used;
   logic         wr_accept;

   // Occupancy is taken against the post-write counter so a write shows up in the flags
   // at the same edge that accepts it.
   always_comb begin
      wr_accept     = write_req & ~full_q;
      wr_cntr_next  = wr_cntr + W'(wr_accept);
      rd_sync1_d    = rd_gray_async;
      rd_sync2_d    = rd_sync1_q;
      rd_bin        = gray2bin(rd_sync2_q);
      used          = wr_cntr_next - rd_bin;
      full_d        = (used == DEPTH);
      free_cnt_d    = DEPTH - used;
      almost_full_d = (32'(free_cnt_d) <= af_level);
      wr_gray_d     = (wr_cntr_next >> 1) ^ wr_cntr_next;
      wr_overflow_d = wr_overflow_q | (write_req & full_q);
   end

   always_ff @(posedge clk_write) begin
      if (!rst_n) begin
         rd_sync1_q    <= '0;
         rd_sync2_q    <= '0;
         wr_gray_q     <= '0;
         free_cnt_q    <= DEPTH;
         full_q        <= 1'b0;
         almost_full_q <= AF_RESET;
         wr_overflow_q <= 1'b0;
      end else begin
         rd_sync1_q    <= rd_sync1_d;
         rd_sync2_q    <= rd_sync2_d;
         wr_gray_q     <= wr_gray_d;
         free_cnt_q    <= free_cnt_d;
         full_q        <= full_d;
         almost_full_q <= almost_full_d;
         wr_overflow_q <= wr_overflow_d;
      end
   end

   assign write_to_stk = wr_accept;
   assign wr_gray      = wr_gray_q;
   assign full         = full_q;
   assign almost_full  = almost_full_q;
   assign free_cnt     = free_cnt_q;
   assign wr_overflow  = wr_overflow_q;

endmodule

// File: tb/tb_wr_full_unit.sv
// Directed bench for wr_full_unit (DEPTH=8, af_level=2) with a behavioural write counter.
module tb_wr_full_unit;

   logic       clk_write = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] wr_cntr;
   logic       write_req = 1'b0;
   logic [3:0] rd_gray_async = 4'h0;
   logic       write_to_stk;
   logic [3:0] wr_gray;
   logic       full;
   logic       almost_full;
   logic [3:0] free_cnt;
   logic       wr_overflow;

   int checks = 0;
   int failures = 0;

   always #5 clk_write = ~clk_write;

   wr_full_unit #(.stk_ptr_width(3), .af_level(2)) dut (
      .clk_write     (clk_write),
      .rst_n         (rst_n),
      .wr_cntr       (wr_cntr),
      .write_req     (write_req),
      .rd_gray_async (rd_gray_async),
      .write_to_stk  (write_to_stk),
      .wr_gray       (wr_gray),
      .full          (full),
      .almost_full   (almost_full),
      .free_cnt      (free_cnt),
      .wr_overflow   (wr_overflow)
   );

   // Write counter unit: advances on the qualified strobe, cleared by the same reset.
   always_ff @(posedge clk_write) begin
      if (!rst_n) wr_cntr <= 4'h0;
      else if (write_to_stk) wr_cntr <= wr_cntr + 4'h1;
   end

   typedef struct {
      logic       rst_n;
      logic       wreq;
      logic [3:0] rd;
      logic       wts;
      logic       full;
      logic       af;
      logic [3:0] free;
      logic [3:0] gray;
      logic       ovf;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge clk_write);
      rst_n = v.rst_n;
      write_req = v.wreq;
      rd_gray_async = v.rd;
      #1;
      check("write_to_stk", idx, 32'(write_to_stk), 32'(v.wts));
      @(posedge clk_write);
      #1;
      check("full", idx, 32'(full), 32'(v.full));
      check("almost_full", idx, 32'(almost_full), 32'(v.af));
      check("free_cnt", idx, 32'(free_cnt), 32'(v.free));
      check("wr_gray", idx, 32'(wr_gray), 32'(v.gray));
      check("wr_overflow", idx, 32'(wr_overflow), 32'(v.ovf));
   endtask

   task automatic cyc(input logic wreq, input logic [3:0] rd);
      @(negedge clk_write);
      rst_n = 1'b1;
      write_req = wreq;
      rd_gray_async = rd;
      @(posedge clk_write);
      #1;
   endtask

   initial begin
      // rst, wreq, rd, wts, full, af, free, gray, ovf
      vq.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd8, 4'b0000, 1'b0});
      vq.push_back('{1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd7, 4'b0001, 1'b0});
      vq.push_back('{1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd6, 4'b0011, 1'b0});
      vq.push_back('{1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd5, 4'b0010, 1'b0});
      vq.push_back('{1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd4, 4'b0110, 1'b0});
      vq.push_back('{1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd3, 4'b0111, 1'b0});
      vq.push_back('{1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd2, 4'b0101, 1'b0});
      vq.push_back('{1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd1, 4'b0100, 1'b0});
      vq.push_back('{1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 4'd0, 4'b1100, 1'b0});
      // overflow attempt, then request dropped: error stays sticky
      vq.push_back('{1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 4'd0, 4'b1100, 1'b1});
      vq.push_back('{1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'd0, 4'b1100, 1'b1});
      // one read arrives: full drops only on the third edge
      vq.push_back('{1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 4'd0, 4'b1100, 1'b1});
      vq.push_back('{1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 4'd0, 4'b1100, 1'b1});
      vq.push_back('{1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 4'd1, 4'b1100, 1'b1});
      // refill the freed slot
      vq.push_back('{1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 4'd0, 4'b1101, 1'b1});
      // reset while full with overflow set, write requested
      vq.push_back('{1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 4'd8, 4'b0000, 1'b0});
      vq.push_back('{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd8, 4'b0000, 1'b0});

      @(posedge clk_write);
      foreach (vq[i]) apply(vq[i], i);

      // Wrap: walk both counters to wr=15, rd=12, then write across the modulo boundary.
      for (int i = 0; i < 4; i++) cyc(1'b1, 4'b0000);
      for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0110);
      for (int i = 0; i < 4; i++) cyc(1'b1, 4'b0110);
      for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1100);
      for (int i = 0; i < 4; i++) cyc(1'b1, 4'b1100);
      for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1010);
      for (int i = 0; i < 3; i++) cyc(1'b1, 4'b1010);
      cyc(1'b0, 4'b1010);
      check("wrap_pre_cntr", 100, 32'(wr_cntr), 32'd15);
      check("wrap_pre_free", 100, 32'(free_cnt), 32'd5);
      check("wrap_pre_gray", 100, 32'(wr_gray), 32'b1000);
      check("wrap_pre_full", 100, 32'(full), 32'd0);

      @(negedge clk_write);
      write_req = 1'b1;
      #1;
      check("wrap_wts", 101, 32'(write_to_stk), 32'd1);
      @(posedge clk_write);
      #1;
      check("wrap_gray", 101, 32'(wr_gray), 32'b0000);
      check("wrap_free", 101, 32'(free_cnt), 32'd4);
      check("wrap_full", 101, 32'(full), 32'd0);
      check("wrap_af", 101, 32'(almost_full), 32'd0);
      check("wrap_cntr", 101, 32'(wr_cntr), 32'd0);

      @(negedge clk_write);
      write_req = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
